football_robot_ctrl: RTL and testbench
======================================

# football_robot_ctrl

Sequential successor to the three-input football-robot decision function. It debounces N raw sensor lines and looks up a kick decision in a run-time programmable truth table. A Moore FSM then issues a fixed-length kick pulse followed by a cooldown. It sits between the robot's sensor pins and the kicker actuator driver.

## Interface

Parameters:
- N_SENSORS, 3, number of sensor inputs (1..6)
- DEBOUNCE, 4, consecutive cycles a raw change must persist (≥1)
- KICK_CYCLES, 2, kick pulse length in cycles (≥1)
- COOLDOWN, 8, cycles after a kick before re-arming (≥0)
- RETRIGGER, 0, 1: may kick again while decision stays 1; 0: decision must return to 0 first
- LUT_RESET, 8'b1110_0100, reset truth table; bit i = decision for stable vector i (default reproduces the original function: 010, 101, 110, 111 → 1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- sensors  in  N_SENSORS  raw sensor lines
- enable  in  1  permits new kicks from IDLE
- lut_we  in  1  load the whole truth table
- lut_wdata  in  2**N_SENSORS  new truth table
- kick  out  1  actuator drive
- busy  out  1  high in KICK or COOL
- decision  out  1  registered lut[stable]
- stable  out  N_SENSORS  debounced sensor vector

## Operation

Reset (clk edge with rst=1):
- stable=0, all debounce counters=0, lut=LUT_RESET.
- decision=0, state=IDLE, armed=1, kick=0, busy=0.
- rst overrides all other inputs, including a kick in progress.

Debounce, independently per bit:
- If raw==stable, the counter clears to 0.
- Otherwise the counter increments. On the DEBOUNCE-th consecutive differing edge, stable takes raw and the counter clears.
- A glitch shorter than DEBOUNCE cycles never changes stable.

Decision and truth table:
- decision <= lut[stable] every edge.
- lut_we=1 loads lut <= lut_wdata at that edge. The new table is used from the next edge.
- A write during KICK or COOL does not alter that sequence.

FSM (football_robot_pkg::state_t):
- IDLE → KICK when enable && decision && armed. Load cnt=KICK_CYCLES-1.
- KICK: cnt decrements each edge. At cnt==0, go to COOL with cnt=COOLDOWN-1, or straight to IDLE if COOLDOWN==0.
- COOL: cnt decrements. At cnt==0, go to IDLE.
- Outputs are Moore: kick=(state==KICK), busy=(state!=IDLE).
- enable is ignored outside IDLE. Deasserting it mid-kick does not shorten the pulse.

Re-arm:
- RETRIGGER=1: armed is held at 1.
- RETRIGGER=0: armed clears on entering KICK and sets on any edge where decision==0.

Width rules:
- Debounce counter is $clog2(DEBOUNCE+1) bits.
- FSM counter is $clog2(max(KICK_CYCLES,COOLDOWN,1)+1) bits.
- Counters saturate at their terminal values; they do not wrap.

## Timing

- A raw change first sampled at edge 1 updates stable at edge DEBOUNCE, decision at edge DEBOUNCE+1, and state=KICK at edge DEBOUNCE+2.
- End-to-end latency is DEBOUNCE+2 cycles, which is 6 cycles with the defaults.
- kick is high for exactly KICK_CYCLES cycles.
- busy is high for KICK_CYCLES+COOLDOWN cycles.
- Minimum kick-to-kick spacing is KICK_CYCLES+COOLDOWN+1 cycles.
- If decision and enable are both valid on the edge that returns the FSM to IDLE, KICK is entered on the next edge, not the same one.

## Structure

- football_robot_pkg holds:
  - state_t (IDLE, KICK, COOL)
  - the default LUT_RESET constant
  - a function for counter-width calculation
- Sub-module sensor_debounce: single-bit debouncer parameterised by DEBOUNCE. It is instantiated N_SENSORS times in a generate loop.
- The top level holds the LUT register, the decision register and the FSM.

## Test plan

- **Reset defaults:** hold rst 2 cycles with sensors=3'b111 → kick=0, busy=0, stable=000, decision=0. stable becomes 111 four edges after release.
- **Default table and latency:** apply sensors=010 → decision=1 at edge 5, kick high on edges 6–7, busy low again after edge 15. Apply 011 and 100 → no kick.
- **Glitch rejection:** pulse sensors=101 for 3 cycles then return to 000 → stable unchanged, no kick. Hold 101 for 4 cycles → kick.
- **Re-arm modes:** hold sensors=110 for 40 cycles. With RETRIGGER=0 → exactly one kick. With RETRIGGER=1 → a kick every 11 cycles.
- **Table reload mid-kick:** during KICK, write lut_wdata=8'b0000_0001 → current pulse and cooldown complete. Afterwards 110 gives no kick and 000 gives a kick.
- **Reset and enable mid-operation:** assert rst during the second KICK cycle → kick=0 and state=IDLE on that edge. With enable=0 and sensors=111 → no kick; raising enable kicks on the next edge.

Source files
------------

// File: rtl/football_robot_pkg.sv
// Shared types and helpers for the football robot kick controller.
// FSM encodings stay as fixed constants so existing state decoders remain compatible.
package football_robot_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t KICK = 2'd1;
    localparam state_t COOL = 2'd2;

    // Reproduces the original combinational decision: 010, 101, 110, 111 -> kick.
    localparam logic [7:0] LUT_RESET_DEFAULT = 8'b1110_0100;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit debouncer: the output follows the raw line only after it has
// differed from the current output for DEBOUNCE consecutive clock edges.
module sensor_debounce
    import football_robot_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int unsigned   CW   = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt;

    // The counter never passes LAST: reaching it commits the new value and clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (raw == stable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            stable <= raw;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/football_robot_ctrl.sv
// Debounced sensor vector -> programmable truth table -> Moore kick/cooldown FSM
// driving the kicker actuator.
module football_robot_ctrl
    import football_robot_pkg::*;
#(
    parameter int unsigned                   N_SENSORS   = 3,
    parameter int unsigned                   DEBOUNCE    = 4,
    parameter int unsigned                   KICK_CYCLES = 2,
    parameter int unsigned                   COOLDOWN    = 8,
    parameter bit                            RETRIGGER   = 1'b0,
    parameter logic [(1<<N_SENSORS)-1:0]     LUT_RESET   = LUT_RESET_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SENSORS-1:0]          sensors,
    input  logic                          enable,
    input  logic                          lut_we,
    input  logic [(1<<N_SENSORS)-1:0]     lut_wdata,
    output logic                          kick,
    output logic                          busy,
    output logic                          decision,
    output logic [N_SENSORS-1:0]          stable
);

    localparam int unsigned   LUT_W     = 1 << N_SENSORS;
    localparam int unsigned   CW        = cnt_width(max3(KICK_CYCLES, COOLDOWN, 1));
    localparam logic [CW-1:0] KICK_LOAD = CW'(KICK_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'((COOLDOWN == 0) ? 0 : COOLDOWN - 1);

    logic [LUT_W-1:0] lut;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic             armed;
    logic             start;

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_db
        sensor_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw    (sensors[i]),
            .stable (stable[i])
        );
    end

    // decision reads the table as it was before any write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut      <= LUT_RESET;
            decision <= 1'b0;
        end else begin
            decision <= lut[stable];
            if (lut_we) begin
                lut <= lut_wdata;
            end
        end
    end

    always_comb begin
        start = enable && decision && armed;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= KICK;
                        cnt   <= KICK_LOAD;
                    end
                end
                KICK: begin
                    if (cnt == '0) begin
                        if (COOLDOWN == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= COOL;
                            cnt   <= COOL_LOAD;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                COOL: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // A kick needs decision=1, so the re-arm and disarm cases never collide.
            if (RETRIGGER) begin
                armed <= 1'b1;
            end else if (!decision) begin
                armed <= 1'b1;
            end else if (state == IDLE && start) begin
                armed <= 1'b0;
            end
        end
    end

    always_comb begin
        kick = (state == KICK);
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_football_robot_ctrl.sv
// Self-checking bench for football_robot_ctrl: vector table plus timed scoreboard,
// with a second instance built for retrigger mode sharing the same stimulus.
module tb_football_robot_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sensors;
    logic       enable;
    logic       lut_we;
    logic [7:0] lut_wdata;

    logic       kick, busy, decision;
    logic [2:0] stable;
    logic       kick_rt, busy_rt, decision_rt;
    logic [2:0] stable_rt;

    always #5 clk = ~clk;

    football_robot_ctrl #(
        .N_SENSORS   (3),
        .DEBOUNCE    (4),
        .KICK_CYCLES (2),
        .COOLDOWN    (8),
        .RETRIGGER   (1'b0),
        .LUT_RESET   (8'b1110_0100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensors   (sensors),
        .enable    (enable),
        .lut_we    (lut_we),
        .lut_wdata (lut_wdata),
        .kick      (kick),
        .busy      (busy),
        .decision  (decision),
        .stable    (stable)
    );

    football_robot_ctrl #(
        .N_SENSORS   (3),
        .DEBOUNCE    (4),
        .KICK_CYCLES (2),
        .COOLDOWN    (8),
        .RETRIGGER   (1'b1),
        .LUT_RESET   (8'b1110_0100)
    ) dut_rt (
        .clk       (clk),
        .rst       (rst),
        .sensors   (sensors),
        .enable    (enable),
        .lut_we    (lut_we),
        .lut_wdata (lut_wdata),
        .kick      (kick_rt),
        .busy      (busy_rt),
        .decision  (decision_rt),
        .stable    (stable_rt)
    );

    typedef enum int {S_KICK, S_BUSY, S_DEC, S_STABLE, S_KICK_RT} sig_e;

    typedef struct {
        int unsigned at;
        sig_e        sig;
        logic [7:0]  val;
        string       name;
    } exp_t;

    typedef struct {
        logic [2:0] sens;
        logic       en;
        logic       exp_dec;
        logic       exp_kick;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[9];
    int unsigned cyc      = 0;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    int unsigned n0, n1, sp;
    int unsigned t_rt[$];
    logic        p0, p1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] sample(input sig_e s);
        case (s)
            S_KICK:    return {7'd0, kick};
            S_BUSY:    return {7'd0, busy};
            S_DEC:     return {7'd0, decision};
            S_STABLE:  return {5'd0, stable};
            S_KICK_RT: return {7'd0, kick_rt};
            default:   return 8'hxx;
        endcase
    endfunction

    task automatic expect_at(input int unsigned dt, input sig_e s,
                             input logic [7:0] v, input string name);
        exp_t e;
        e.at   = cyc + dt;
        e.sig  = s;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                chk(sb[i].name, sample(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    task automatic settle();
        sensors = 3'b000;
        enable  = 1'b1;
        lut_we  = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3'b000, 1'b1, 1'b0, 1'b0};
        vt[1] = '{3'b001, 1'b1, 1'b0, 1'b0};
        vt[2] = '{3'b010, 1'b1, 1'b1, 1'b1};
        vt[3] = '{3'b011, 1'b1, 1'b0, 1'b0};
        vt[4] = '{3'b100, 1'b1, 1'b0, 1'b0};
        vt[5] = '{3'b101, 1'b1, 1'b1, 1'b1};
        vt[6] = '{3'b110, 1'b1, 1'b1, 1'b1};
        vt[7] = '{3'b111, 1'b1, 1'b1, 1'b1};
        vt[8] = '{3'b010, 1'b0, 1'b1, 1'b0};

        // Reset defaults, then release with 111 already present.
        rst       = 1'b1;
        sensors   = 3'b111;
        enable    = 1'b1;
        lut_we    = 1'b0;
        lut_wdata = 8'h00;
        repeat (2) tick();
        chk("reset_kick",     {7'd0, kick},     8'd0);
        chk("reset_busy",     {7'd0, busy},     8'd0);
        chk("reset_stable",   {5'd0, stable},   8'd0);
        chk("reset_decision", {7'd0, decision}, 8'd0);
        chk("reset_kick_rt",  {7'd0, kick_rt},  8'd0);
        rst = 1'b0;
        expect_at(3,  S_STABLE, 8'd0, "rel_stable_pre");
        expect_at(4,  S_STABLE, 8'd7, "rel_stable_111");
        expect_at(5,  S_DEC,    8'd1, "rel_decision");
        expect_at(6,  S_KICK,   8'd1, "rel_kick_first");
        expect_at(7,  S_KICK,   8'd1, "rel_kick_second");
        expect_at(8,  S_KICK,   8'd0, "rel_kick_end");
        expect_at(15, S_BUSY,   8'd1, "rel_busy_last");
        expect_at(16, S_BUSY,   8'd0, "rel_busy_end");
        repeat (20) tick();
        settle();

        // Default truth table and end-to-end latency for every vector.
        for (int unsigned k = 0; k < 9; k++) begin
            sensors = vt[k].sens;
            enable  = vt[k].en;
            expect_at(3,  S_STABLE,  8'd0,                    "vec_stable_pre");
            expect_at(4,  S_STABLE,  {5'd0, vt[k].sens},      "vec_stable");
            expect_at(5,  S_DEC,     {7'd0, vt[k].exp_dec},   "vec_decision");
            expect_at(5,  S_KICK,    8'd0,                    "vec_kick_early");
            expect_at(6,  S_KICK,    {7'd0, vt[k].exp_kick},  "vec_kick_first");
            expect_at(6,  S_KICK_RT, {7'd0, vt[k].exp_kick},  "vec_kick_rt");
            expect_at(7,  S_KICK,    {7'd0, vt[k].exp_kick},  "vec_kick_second");
            expect_at(8,  S_KICK,    8'd0,                    "vec_kick_end");
            expect_at(15, S_BUSY,    {7'd0, vt[k].exp_kick},  "vec_busy_last");
            expect_at(16, S_BUSY,    8'd0,                    "vec_busy_end");
            repeat (18) tick();
            settle();
        end

        // Glitch of DEBOUNCE-1 cycles is rejected.
        for (int unsigned d = 1; d <= 9; d++) begin
            expect_at(d, S_STABLE, 8'd0, "glitch_stable");
            expect_at(d, S_KICK,   8'd0, "glitch_kick");
        end
        sensors = 3'b101;
        repeat (3) tick();
        sensors = 3'b000;
        repeat (6) tick();

        // Exactly DEBOUNCE cycles is accepted.
        expect_at(4, S_STABLE, 8'd5, "hold4_stable");
        expect_at(8, S_STABLE, 8'd0, "hold4_stable_back");
        expect_at(5, S_DEC,    8'd1, "hold4_decision");
        expect_at(6, S_KICK,   8'd1, "hold4_kick");
        expect_at(7, S_KICK,   8'd1, "hold4_kick_second");
        sensors = 3'b101;
        repeat (4) tick();
        sensors = 3'b000;
        repeat (14) tick();
        settle();

        // Re-arm: one kick without retrigger, one every 11 cycles with it.
        sensors = 3'b110;
        n0 = 0;
        n1 = 0;
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (kick && !p0) n0++;
            if (kick_rt && !p1) begin
                n1++;
                t_rt.push_back(cyc);
            end
            p0 = kick;
            p1 = kick_rt;
        end
        chk("rearm_single_kick", 8'(n0), 8'd1);
        chk("retrig_kick_count", 8'(n1), 8'd4);
        sp = (t_rt.size() >= 2) ? (t_rt[1] - t_rt[0]) : 0;
        chk("retrig_spacing", 8'(sp), 8'd11);
        sensors = 3'b000;
        repeat (14) tick();
        settle();

        // Table reload in the middle of a kick.
        sensors = 3'b110;
        expect_at(6,  S_KICK, 8'd1, "reload_kick_first");
        expect_at(7,  S_KICK, 8'd1, "reload_kick_second");
        expect_at(8,  S_KICK, 8'd0, "reload_kick_end");
        expect_at(8,  S_DEC,  8'd0, "reload_decision_new");
        expect_at(15, S_BUSY, 8'd1, "reload_busy_last");
        expect_at(16, S_BUSY, 8'd0, "reload_busy_end");
        repeat (6) tick();
        lut_we    = 1'b1;
        lut_wdata = 8'b0000_0001;
        tick();
        lut_we = 1'b0;
        for (int unsigned d = 10; d <= 18; d++) begin
            expect_at(d, S_KICK, 8'd0, "reload_110_nokick");
        end
        repeat (20) tick();
        sensors = 3'b000;
        expect_at(4, S_STABLE, 8'd0, "reload_stable_000");
        expect_at(5, S_DEC,    8'd1, "reload_decision_000");
        expect_at(6, S_KICK,   8'd1, "reload_kick_000");
        expect_at(7, S_KICK,   8'd1, "reload_kick_000_second");
        repeat (7) tick();
        lut_we    = 1'b1;
        lut_wdata = 8'b1110_0100;
        tick();
        lut_we = 1'b0;
        settle();

        // Reset during the second kick cycle, then enable gating.
        sensors = 3'b111;
        expect_at(6, S_KICK, 8'd1, "rstmid_kick_first");
        expect_at(7, S_KICK, 8'd1, "rstmid_kick_second");
        repeat (7) tick();
        rst = 1'b1;
        tick();
        chk("rstmid_kick",    {7'd0, kick},    8'd0);
        chk("rstmid_busy",    {7'd0, busy},    8'd0);
        chk("rstmid_busy_rt", {7'd0, busy_rt}, 8'd0);
        chk("rstmid_stable",  {5'd0, stable},  8'd0);
        rst    = 1'b0;
        enable = 1'b0;
        n0 = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (kick || kick_rt) n0++;
        end
        chk("disabled_nokick",   8'(n0),            8'd0);
        chk("disabled_decision", {7'd0, decision},  8'd1);
        enable = 1'b1;
        tick();
        chk("enable_kick",    {7'd0, kick},    8'd1);
        chk("enable_kick_rt", {7'd0, kick_rt}, 8'd1);
        repeat (2) tick();
        chk("enable_kick_len", {7'd0, kick}, 8'd0);
        chk("enable_busy",     {7'd0, busy}, 8'd1);

        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
